// File: rtl/tx_lvds_framer.sv
// Serial frame transmitter: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// A one-word holding buffer behind a ready/valid handshake lets frames run back-to-back.
module tx_lvds_framer #(
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int MSB_FIRST    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_of(input logic [DATA_W-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [DIV_W-1:0]   div_r, div_nxt_s;
    logic [BIT_W-1:0]   bit_r, bit_nxt_s;
    logic [DATA_W-1:0]  shift_r, shift_nxt_s;
    logic [DATA_W-1:0]  hold_r;
    logic               hold_full_r, hold_full_nxt_s;
    logic               par_r, par_nxt_s;
    logic               tx_nxt_s, done_nxt_s;
    logic               accept_s, bit_end_s, stop_end_s, load_s;

    assign accept_s   = tx_valid && tx_ready;
    assign bit_end_s  = (state_r != S_IDLE) && (div_r == DIV_LAST);
    assign stop_end_s = (state_r == S_STOP) && bit_end_s && (bit_r == STOP_LAST);
    assign load_s     = ((state_r == S_IDLE) || stop_end_s) && hold_full_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (hold_full_r) state_nxt_s = S_START;
                else             state_nxt_s = S_IDLE;
            end
            S_START: begin
                if (bit_end_s) state_nxt_s = S_DATA;
                else           state_nxt_s = S_START;
            end
            S_DATA: begin
                if (bit_end_s && (bit_r == DATA_LAST)) begin
                    if (PARITY_EN != 0) state_nxt_s = S_PARITY;
                    else                state_nxt_s = S_STOP;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) state_nxt_s = S_STOP;
                else           state_nxt_s = S_PARITY;
            end
            S_STOP: begin
                // A pending word starts its frame with no idle gap
                if (stop_end_s) state_nxt_s = hold_full_r ? S_START : S_IDLE;
                else            state_nxt_s = S_STOP;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Divider, bit counter, shifter, parity and holding-buffer next values
    always_comb begin
        div_nxt_s       = div_r;
        bit_nxt_s       = bit_r;
        shift_nxt_s     = shift_r;
        par_nxt_s       = par_r;
        hold_full_nxt_s = hold_full_r;

        if (state_r == S_IDLE) begin
            div_nxt_s = {DIV_W{1'b0}};
            bit_nxt_s = {BIT_W{1'b0}};
        end else if (bit_end_s) begin
            div_nxt_s = {DIV_W{1'b0}};
            if (state_nxt_s == state_r) bit_nxt_s = bit_r + BIT_ONE;
            else                        bit_nxt_s = {BIT_W{1'b0}};
        end else begin
            div_nxt_s = div_r + DIV_ONE;
        end

        if (load_s) begin
            shift_nxt_s = hold_r;
            par_nxt_s   = parity_of(hold_r, ODD_BIT);
        end else if ((state_r == S_DATA) && bit_end_s) begin
            if (MSB_FIRST != 0) shift_nxt_s = shift_r << 1'b1;
            else                shift_nxt_s = shift_r >> 1'b1;
        end else begin
            shift_nxt_s = shift_r;
        end

        if (accept_s)    hold_full_nxt_s = 1'b1;
        else if (load_s) hold_full_nxt_s = 1'b0;
        else             hold_full_nxt_s = hold_full_r;
    end

    // Line level and completion pulse for the coming cycle
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            S_IDLE:   tx_nxt_s = 1'b1;
            S_START:  tx_nxt_s = 1'b0;
            S_DATA: begin
                if (MSB_FIRST != 0) tx_nxt_s = shift_nxt_s[DATA_W-1];
                else                tx_nxt_s = shift_nxt_s[0];
            end
            S_PARITY: tx_nxt_s = par_nxt_s;
            S_STOP:   tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
        done_nxt_s = (state_nxt_s == S_STOP) && (div_nxt_s == DIV_LAST) &&
                     (bit_nxt_s == STOP_LAST);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r       <= {DIV_W{1'b0}};
            bit_r       <= {BIT_W{1'b0}};
            shift_r     <= {DATA_W{1'b0}};
            hold_r      <= {DATA_W{1'b0}};
            hold_full_r <= 1'b0;
            par_r       <= 1'b0;
        end else begin
            div_r       <= div_nxt_s;
            bit_r       <= bit_nxt_s;
            shift_r     <= shift_nxt_s;
            hold_r      <= accept_s ? data_in : hold_r;
            hold_full_r <= hold_full_nxt_s;
            par_r       <= par_nxt_s;
        end
    end

    // Output registers; reset forces the line high without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_nxt_s;
            tx_ready   <= !hold_full_nxt_s;
            tx_busy    <= (state_nxt_s != S_IDLE) || hold_full_nxt_s;
            frame_done <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_tx_lvds_framer.sv
// Bench for tx_lvds_framer: four parameter variants, directed frame vectors,
// back-to-back and mid-frame reset sequences, and random traffic against a frame-level model.
module tb_tx_lvds_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [7:0] din [4];
    wire  [3:0] tx_v, rdy_v, busy_v, done_v;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    localparam int C_CLKS [4] = '{1, 1, 4, 2};
    localparam int C_STOP [4] = '{1, 1, 2, 1};
    localparam int C_PEN  [4] = '{0, 1, 0, 1};
    localparam int C_PODD [4] = '{0, 0, 0, 1};
    localparam int C_MSB  [4] = '{0, 1, 0, 0};

    always #5 clk = ~clk;

    tx_lvds_framer #(.DATA_W(8)) u0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .tx_valid(vld[0]), .tx_ready(rdy_v[0]),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .frame_done(done_v[0]));
    tx_lvds_framer #(.DATA_W(8), .PARITY_EN(1), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .tx_valid(vld[1]), .tx_ready(rdy_v[1]),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .frame_done(done_v[1]));
    tx_lvds_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .tx_valid(vld[2]), .tx_ready(rdy_v[2]),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .frame_done(done_v[2]));
    tx_lvds_framer #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .rst(rst), .data_in(din[3]), .tx_valid(vld[3]), .tx_ready(rdy_v[3]),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .frame_done(done_v[3]));

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of line levels; a word waits in 'pending'
    // until the line has no frame left, then its whole frame is queued.
    bit         fq    [4][64];
    int         frem  [4];
    int         fpos  [4];
    bit         mpend [4];
    logic [7:0] mword [4];
    bit         m_acc;
    bit         m_b   [12];
    int         m_nb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 4; u++) begin
                frem[u] = 0; fpos[u] = 0; mpend[u] = 1'b0;
            end
        end else begin
            for (int u = 0; u < 4; u++) begin
                m_acc = vld[u] && !mpend[u];
                if (frem[u] > 0) begin
                    fpos[u]++; frem[u]--;
                end
                if (frem[u] == 0 && mpend[u]) begin
                    m_b[0] = 1'b0;
                    for (int k = 0; k < 8; k++)
                        m_b[1+k] = (C_MSB[u] != 0) ? mword[u][7-k] : mword[u][k];
                    m_nb = 9;
                    if (C_PEN[u] != 0) begin
                        m_b[m_nb] = ((($countones(mword[u]) % 2) == 1) != (C_PODD[u] != 0));
                        m_nb++;
                    end
                    for (int s = 0; s < C_STOP[u]; s++) begin
                        m_b[m_nb] = 1'b1; m_nb++;
                    end
                    fpos[u] = 0;
                    for (int k = 0; k < m_nb; k++)
                        for (int c = 0; c < C_CLKS[u]; c++) begin
                            fq[u][frem[u]] = m_b[k]; frem[u]++;
                        end
                    mpend[u] = 1'b0;
                end
                if (m_acc) begin
                    mpend[u] = 1'b1; mword[u] = din[u];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int u = 0; u < 4; u++) begin
                chk($sformatf("model u%0d tx", u), tx_v[u], (frem[u] > 0) ? fq[u][fpos[u]] : 1'b1);
                chk($sformatf("model u%0d ready", u), rdy_v[u], !mpend[u]);
                chk($sformatf("model u%0d busy", u), busy_v[u], (frem[u] > 0) || mpend[u]);
                chk($sformatf("model u%0d done", u), done_v[u], frem[u] == 1);
            end
        end
    end

    typedef struct {
        int          unit;
        logic [7:0]  word;
        int          nbits;
        logic [11:0] bits;   // first line bit in position nbits-1
    } vec_t;
    vec_t tbl [8];

    task automatic run_vec(input int u, input logic [7:0] w, input int nbits, input logic [11:0] bits);
        @(negedge clk);
        chk($sformatf("vec u%0d ready idle", u), rdy_v[u], 1'b1);
        vld[u] = 1'b1; din[u] = w;
        @(negedge clk);
        vld[u] = 1'b0;
        chk($sformatf("vec u%0d hold tx", u), tx_v[u], 1'b1);
        chk($sformatf("vec u%0d hold busy", u), busy_v[u], 1'b1);
        for (int k = 0; k < nbits; k++)
            for (int c = 0; c < C_CLKS[u]; c++) begin
                @(negedge clk);
                chk($sformatf("vec u%0d %h bit%0d tx", u, w, k), tx_v[u], bits[nbits-1-k]);
                chk($sformatf("vec u%0d %h bit%0d done", u, w, k), done_v[u],
                    (k == nbits - 1) && (c == C_CLKS[u] - 1));
                chk($sformatf("vec u%0d %h bit%0d busy", u, w, k), busy_v[u], 1'b1);
            end
        @(negedge clk);
        chk($sformatf("vec u%0d after busy", u), busy_v[u], 1'b0);
        chk($sformatf("vec u%0d after tx", u), tx_v[u], 1'b1);
    endtask

    logic [19:0] bb;

    initial begin
        tbl[0] = '{0, 8'hA5, 10, 12'b0101001011};
        tbl[1] = '{0, 8'h01, 10, 12'b0100000001};
        tbl[2] = '{1, 8'h01, 11, 12'b00000000111};
        tbl[3] = '{1, 8'hA5, 11, 12'b01010010101};
        tbl[4] = '{1, 8'h07, 11, 12'b00000011111};
        tbl[5] = '{3, 8'h07, 11, 12'b01110000001};
        tbl[6] = '{2, 8'hFF, 11, 12'b01111111111};
        tbl[7] = '{3, 8'hA5, 11, 12'b01010010111};

        rst = 1'b0; vld = 4'b0000;
        for (int u = 0; u < 4; u++) din[u] = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset u%0d tx", u), tx_v[u], 1'b1);
            chk($sformatf("reset u%0d ready", u), rdy_v[u], 1'b1);
            chk($sformatf("reset u%0d busy", u), busy_v[u], 1'b0);
            chk($sformatf("reset u%0d done", u), done_v[u], 1'b0);
        end
        rst = 1'b0;
        chk_on = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i].unit, tbl[i].word, tbl[i].nbits, tbl[i].bits);

        // Back-to-back: 0x00 then 0xFF with tx_valid held
        bb = 20'b0000000001_0111111111;
        @(negedge clk); vld[0] = 1'b1; din[0] = 8'h00;
        @(negedge clk);
        chk("b2b ready after first accept", rdy_v[0], 1'b0);
        din[0] = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("b2b tx cycle%0d", k), tx_v[0], bb[19-k]);
            chk($sformatf("b2b done cycle%0d", k), done_v[0], (k == 9) || (k == 19));
            if (k == 0) chk("b2b ready after reload", rdy_v[0], 1'b1);
            if (k == 1) begin
                chk("b2b ready after second accept", rdy_v[0], 1'b0);
                vld[0] = 1'b0;
            end
            if (k == 10) chk("b2b ready after second reload", rdy_v[0], 1'b1);
        end
        @(negedge clk);
        chk("b2b idle busy", busy_v[0], 1'b0);

        // Reset during data bit 4 with a word pending
        @(negedge clk); vld[0] = 1'b1; din[0] = 8'hA5;
        @(negedge clk); din[0] = 8'h3C;
        @(negedge clk);
        @(negedge clk); vld[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst pre tx bit4", tx_v[0], 1'b0);
        chk("rst pre ready", rdy_v[0], 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst async tx", tx_v[0], 1'b1);
        chk("rst async busy", busy_v[0], 1'b0);
        chk("rst async ready", rdy_v[0], 1'b1);
        chk("rst async done", done_v[0], 1'b0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rst post tx", tx_v[0], 1'b1);
            chk("rst post busy", busy_v[0], 1'b0);
        end

        // Random traffic; a word not yet accepted is held stable
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int u = 0; u < 4; u++) begin
                if (!(vld[u] && mpend[u])) begin
                    vld[u] = ($urandom_range(0, 3) != 0);
                    din[u] = 8'($urandom);
                end
            end
        end
        vld = 4'b0000;
        repeat (120) @(negedge clk);
        for (int u = 0; u < 4; u++)
            chk($sformatf("drain u%0d busy", u), busy_v[u], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
